// File: rtl/accumulator_pkg.sv
// Shared types and constants for the accumulator sequencer.
// Width defaults and saturation limits for the 18-bit datapath.
package accumulator_pkg;

    localparam int DATA_W = 18;
    localparam int CNT_W  = 8;

    localparam logic [17:0] SAT_MAX = 18'h1FFFF;
    localparam logic [17:0] SAT_MIN = 18'h20000;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DONE
    } state_t;

endpackage

// File: rtl/accumulator_sat_add.sv
// Signed two's-complement adder that clamps to the representable range.
// o_ovf flags that a clamp was applied.
module sat_add #(
    parameter int W = accumulator_pkg::DATA_W
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_ovf
);

    logic [W:0] w_wide;

    assign w_wide = {i_a[W-1], i_a} + {i_b[W-1], i_b};

    // Top two bits disagree only when the true sum left the W-bit range.
    always_comb begin
        o_ovf = w_wide[W] ^ w_wide[W-1];
        o_sum = w_wide[W-1:0];
        if (o_ovf) begin
            o_sum = w_wide[W] ? {1'b1, {(W-1){1'b0}}}
                              : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/accumulator_ctrl.sv
// Sequencer for the external accumulator register: clear, accumulate
// a counted operand stream with saturation, then hand off the result.
module accumulator_ctrl #(
    parameter int DATA_W = accumulator_pkg::DATA_W,
    parameter int CNT_W  = accumulator_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              acc_clear,
    output logic [DATA_W-1:0] acc_datain,
    input  logic [DATA_W-1:0] acc_dataout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat
);

    import accumulator_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sat;
    logic              w_in_hs;
    logic              w_ovf;
    logic [DATA_W-1:0] w_sum;

    sat_add #(
        .W(DATA_W)
    ) u_sat_add (
        .i_a   (acc_dataout),
        .i_b   (in_data),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    assign w_in_hs  = in_valid && in_ready;
    assign out_data = acc_dataout;
    assign out_sat  = r_sat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_cnt <= len;
            r_sat <= 1'b0;
        end else if (w_in_hs) begin
            r_cnt <= r_cnt - CNT_ONE;
            r_sat <= r_sat | w_ovf;
        end
    end

    always_comb begin
        w_next     = r_state;
        busy       = 1'b1;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        acc_clear  = 1'b0;
        acc_datain = acc_dataout;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = CLEAR;
            end
            CLEAR: begin
                acc_clear  = 1'b1;
                acc_datain = '0;
                w_next     = (r_cnt == '0) ? DONE : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_datain = w_sum;
                    if (r_cnt == CNT_ONE) w_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // Zero the accumulator on the edge(s) seen while reset is held.
        if (!reset) begin
            acc_clear  = 1'b1;
            acc_datain = '0;
        end
    end

endmodule

// File: doc/accumulator_ctrl.md
# accumulator_ctrl

Sequencer for the 18-bit accumulator register in the datapath. On a start command it clears the accumulator, accepts a programmed number of signed operands over a valid/ready stream, and drives the accumulator input with the saturated running sum. It then presents the final sum on a valid/ready result port. The accumulator loads its input on every clock edge, so this block also drives the hold value on idle cycles.

## Interface
- DATA_W, 18, operand/accumulator width (two's complement)
- CNT_W, 8, width of operand count (max 255 operands per job)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  job request, sampled only in IDLE
- len  in  CNT_W  operand count for the job, latched with start; 0 is legal
- busy  out  1  high in every state except IDLE
- in_valid  in  1  operand valid
- in_ready  out  1  operand accepted when in_valid && in_ready
- in_data  in  DATA_W  signed operand
- acc_clear  out  1  to the accumulator's synchronous active-high clear
- acc_datain  out  DATA_W  next accumulator value
- acc_dataout  in  DATA_W  current accumulator value
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  DATA_W  final sum (equals acc_dataout)
- out_sat  out  1  at least one saturation occurred in this job

## Operation
- States: IDLE, CLEAR, ACCUM, DONE.
- IDLE:
  - busy=0, in_ready=0, out_valid=0.
  - On start: latch len into the remaining-count register, clear the sticky sat flag, go to CLEAR.
- CLEAR:
  - acc_clear=1 and acc_datain=0 for exactly one cycle.
  - Next state is DONE if the latched len is 0, else ACCUM.
- ACCUM:
  - in_ready=1.
  - On a handshake, acc_datain = sat(acc_dataout + in_data), the remaining count decrements, and out_sat |= overflow.
  - When the handshake takes the count from 1 to 0, go to DONE.
  - With no handshake, acc_datain = acc_dataout (hold).
- DONE:
  - out_valid=1; out_data = acc_dataout, held stable until the handshake.
  - On out_valid && out_ready, go to IDLE.
- In IDLE and DONE, acc_datain = acc_dataout (hold).
- Arithmetic:
  - Operands are sign-extended to DATA_W+1 and added.
  - If the sum exceeds 2^(DATA_W-1)-1, clamp to 0x1FFFF (+131071).
  - If the sum is below -2^(DATA_W-1), clamp to 0x20000 (-131072).
  - Each clamp sets out_sat.
- Simultaneous events and boundaries:
  - start outside IDLE is ignored, and len is not re-latched.
  - in_valid outside ACCUM is not accepted (in_ready=0).
  - After a clamp, later operands add to the clamped value; there is no wrap-around.
- Reset low, at any time:
  - State goes to IDLE and the counter and sat flag go to 0.
  - acc_clear = 1 combinationally while reset is low, so the accumulator is zeroed on the next edge.
  - A job in flight is abandoned with no output.
- Reset values: busy=0, in_ready=0, out_valid=0, out_sat=0, acc_clear=1 (while in reset), acc_datain=0.
  - out_data follows acc_dataout, which reads 0 once the accumulator has been clocked in reset.

## Timing
- Start sampled at edge E0. CLEAR runs in cycle E0..E1, and the accumulator reads 0 after E1.
- ACCUM begins at E1. Operands stream at one per cycle with no bubble.
- Each accepted operand is in the accumulator at the same edge it is accepted.
- With len=N and in_valid held high, out_valid rises after edge E0+N+1.
- With len=0, out_valid rises after E1 and out_data=0.
- The earliest new start is the cycle after the out handshake.

## Structure
- Package accumulator_pkg holds:
  - the state enum (IDLE, CLEAR, ACCUM, DONE);
  - DATA_W and CNT_W defaults;
  - SAT_MAX = 18'h1FFFF and SAT_MIN = 18'h20000.
- Sub-module sat_add: combinational DATA_W signed add with clamp and overflow flag. It is instanced once for the acc_datain path.
- The FSM, counter and sat flag live in accumulator_ctrl.
- The bench pairs accumulator_ctrl with an accumulator register model (synchronous clear, loads every edge).

## Test plan
- len=3, operands 5, -2, 10, in_valid held high: out_data=13, out_sat=0, out_valid after E0+4.
- len=2, operands 100000, 100000: out_data=0x1FFFF; then a new job len=2 of -100000, -100000 gives out_data=0x20000; out_sat=1 for both.
- len=3, operands 131071, 5, -10: clamps to 131071 and then gives 131061 (no wrap), out_sat=1.
- len=0: no in_ready pulse, acc_clear for one cycle, out_valid after E1 with out_data=0 and out_sat=0.
- len=4 with in_valid toggled 1,0,1,1,0,1, out_ready low for 5 cycles, and start pulsed during ACCUM and DONE:
  - the accumulator holds on idle cycles;
  - out_data stays stable while stalled;
  - the extra starts are ignored;
  - sum is correct.
- reset driven low for one cycle mid-ACCUM after 2 of 5 operands:
  - all outputs return to reset values and the accumulator is 0 at the next edge;
  - a following job len=1, operand 7 returns 7.
